// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle controller.
// Contents:
// - state_e: 4-bit FSM state encoding.
// - Opcode constants for the instruction op field.
// - ALU control codes driven on alucontrol.
package mc_pkg;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StAluWb  = 4'd7,
    StBranch = 4'd8,
    StAddiEx = 4'd9,
    StAddiWb = 4'd10,
    StJump   = 4'd11
  } state_e;

  localparam logic [3:0] OpRtype = 4'd0;
  localparam logic [3:0] OpLw    = 4'd1;
  localparam logic [3:0] OpSw    = 4'd2;
  localparam logic [3:0] OpBeq   = 4'd3;
  localparam logic [3:0] OpAddi  = 4'd4;
  localparam logic [3:0] OpJ     = 4'd5;

  localparam logic [3:0] AluAnd = 4'b0000;
  localparam logic [3:0] AluOr  = 4'b0001;
  localparam logic [3:0] AluAdd = 4'b0010;
  localparam logic [3:0] AluSub = 4'b0110;
  localparam logic [3:0] AluSlt = 4'b0111;

endpackage

// File: rtl/mc_aludec.sv
// R-type ALU decoder: maps the funct field to an ALU control code.
// Ports:
//   funct_i      - function field from the instruction register
//   alucontrol_o - ALU operation; unknown functs fall back to ADD
module mc_aludec
  import mc_pkg::*;
(
  input  logic [3:0] funct_i,
  output logic [3:0] alucontrol_o
);

  always_comb begin
    alucontrol_o = AluAdd;
    case (funct_i)
      4'd0:    alucontrol_o = AluAdd;
      4'd1:    alucontrol_o = AluSub;
      4'd2:    alucontrol_o = AluAnd;
      4'd3:    alucontrol_o = AluOr;
      4'd4:    alucontrol_o = AluSlt;
      default: alucontrol_o = AluAdd;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle processor controller: a Moore FSM sequencing fetch, decode,
// execute, memory and writeback steps, with all datapath controls decoded
// from the state register.
// Ports:
//   clk_i, reset_i       - clock and synchronous active-high reset
//   op_i, funct_i        - instruction opcode and R-type function field
//   zero_i               - ALU zero flag (branch decision)
//   mem_ready_i          - memory access completes in a cycle with this high
//   iord_o .. pcen_o     - datapath mux selects and write enables
//   alucontrol_o         - ALU operation
//   illegal_o            - one-cycle pulse in DECODE for an unknown opcode
//   state_o              - current state, debug only
module mc_controller
  import mc_pkg::*;
#(
  parameter int unsigned n = 32
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [3:0] op_i,
  input  logic [3:0] funct_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       iord_o,
  output logic       irwrite_o,
  output logic       memread_o,
  output logic       memwrite_o,
  output logic       regwrite_o,
  output logic       regdst_o,
  output logic       memtoreg_o,
  output logic       alusrca_o,
  output logic [1:0] alusrcb_o,
  output logic [1:0] pcsrc_o,
  output logic       pcen_o,
  output logic [3:0] alucontrol_o,
  output logic       illegal_o,
  output logic [3:0] state_o
);

  // Width is shared with sibling blocks; the controller itself is width-agnostic.
  logic unused_n;
  assign unused_n = (n != 0);

  state_e     state_q, state_d;
  logic [3:0] funct_alu;

  mc_aludec u_aludec (
    .funct_i      (funct_i),
    .alucontrol_o (funct_alu)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    iord_o       = 1'b0;
    irwrite_o    = 1'b0;
    memread_o    = 1'b0;
    memwrite_o   = 1'b0;
    regwrite_o   = 1'b0;
    regdst_o     = 1'b0;
    memtoreg_o   = 1'b0;
    alusrca_o    = 1'b0;
    alusrcb_o    = 2'b00;
    pcsrc_o      = 2'b00;
    pcen_o       = 1'b0;
    alucontrol_o = AluAdd;
    illegal_o    = 1'b0;
    state_o      = state_q;

    case (state_q)
      StFetch: begin
        // PC+4 and IR load commit only in the cycle the fetch completes.
        memread_o = 1'b1;
        alusrcb_o = 2'b01;
        irwrite_o = mem_ready_i;
        pcen_o    = mem_ready_i;
        if (mem_ready_i) state_d = StDecode;
      end
      StDecode: begin
        alusrcb_o = 2'b11;
        case (op_i)
          OpRtype:     state_d = StExec;
          OpLw, OpSw:  state_d = StMemAdr;
          OpBeq:       state_d = StBranch;
          OpAddi:      state_d = StAddiEx;
          OpJ:         state_d = StJump;
          default: begin
            state_d   = StFetch;
            illegal_o = 1'b1;
          end
        endcase
      end
      StMemAdr: begin
        alusrca_o = 1'b1;
        alusrcb_o = 2'b10;
        state_d   = (op_i == OpSw) ? StMemWr : StMemRd;
      end
      StMemRd: begin
        iord_o    = 1'b1;
        memread_o = 1'b1;
        if (mem_ready_i) state_d = StMemWb;
      end
      StMemWb: begin
        regwrite_o = 1'b1;
        memtoreg_o = 1'b1;
        state_d    = StFetch;
      end
      StMemWr: begin
        iord_o     = 1'b1;
        memwrite_o = 1'b1;
        if (mem_ready_i) state_d = StFetch;
      end
      StExec: begin
        alusrca_o    = 1'b1;
        alucontrol_o = funct_alu;
        state_d      = StAluWb;
      end
      StAluWb: begin
        regwrite_o = 1'b1;
        regdst_o   = 1'b1;
        state_d    = StFetch;
      end
      StBranch: begin
        alusrca_o    = 1'b1;
        alucontrol_o = AluSub;
        pcsrc_o      = 2'b01;
        pcen_o       = zero_i;
        state_d      = StFetch;
      end
      StAddiEx: begin
        alusrca_o = 1'b1;
        alusrcb_o = 2'b10;
        state_d   = StAddiWb;
      end
      StAddiWb: begin
        regwrite_o = 1'b1;
        state_d    = StFetch;
      end
      StJump: begin
        pcsrc_o = 2'b10;
        pcen_o  = 1'b1;
        state_d = StFetch;
      end
      default: state_d = StFetch;
    endcase

    // Reset silences every output immediately, so an interrupted instruction
    // never commits a write or PC update during the reset cycles.
    if (reset_i) begin
      iord_o       = 1'b0;
      irwrite_o    = 1'b0;
      memread_o    = 1'b0;
      memwrite_o   = 1'b0;
      regwrite_o   = 1'b0;
      regdst_o     = 1'b0;
      memtoreg_o   = 1'b0;
      alusrca_o    = 1'b0;
      alusrcb_o    = 2'b00;
      pcsrc_o      = 2'b00;
      pcen_o       = 1'b0;
      alucontrol_o = 4'b0000;
      illegal_o    = 1'b0;
      state_o      = 4'd0;
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// Directed self-checking bench for mc_controller. Each check compares the
// full output bundle against a hand-built expected vector.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] op;
  logic [3:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       iord, irwrite, memread, memwrite, regwrite, regdst, memtoreg, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic       pcen, illegal;
  logic [3:0] alucontrol, state;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mc_controller #(.n(32)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .op_i         (op),
    .funct_i      (funct),
    .zero_i       (zero),
    .mem_ready_i  (mem_ready),
    .iord_o       (iord),
    .irwrite_o    (irwrite),
    .memread_o    (memread),
    .memwrite_o   (memwrite),
    .regwrite_o   (regwrite),
    .regdst_o     (regdst),
    .memtoreg_o   (memtoreg),
    .alusrca_o    (alusrca),
    .alusrcb_o    (alusrcb),
    .pcsrc_o      (pcsrc),
    .pcen_o       (pcen),
    .alucontrol_o (alucontrol),
    .illegal_o    (illegal),
    .state_o      (state)
  );

  // Bundle order: iord irwrite memread memwrite regwrite regdst memtoreg alusrca
  //               alusrcb[2] pcsrc[2] pcen alucontrol[4] illegal state[4]
  logic [21:0] obs;
  assign obs = {iord, irwrite, memread, memwrite, regwrite, regdst, memtoreg, alusrca,
                alusrcb, pcsrc, pcen, alucontrol, illegal, state};

  // State codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6,
  // ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11.
  localparam logic [21:0] VReset   = 22'd0;
  localparam logic [21:0] VFetchR  = {8'b0110_0000, 2'b01, 2'b00, 1'b1, 4'b0010, 1'b0, 4'd0};
  localparam logic [21:0] VFetchW  = {8'b0010_0000, 2'b01, 2'b00, 1'b0, 4'b0010, 1'b0, 4'd0};
  localparam logic [21:0] VDecode  = {8'b0000_0000, 2'b11, 2'b00, 1'b0, 4'b0010, 1'b0, 4'd1};
  localparam logic [21:0] VDecIll  = {8'b0000_0000, 2'b11, 2'b00, 1'b0, 4'b0010, 1'b1, 4'd1};
  localparam logic [21:0] VMemAdr  = {8'b0000_0001, 2'b10, 2'b00, 1'b0, 4'b0010, 1'b0, 4'd2};
  localparam logic [21:0] VMemRd   = {8'b1010_0000, 2'b00, 2'b00, 1'b0, 4'b0010, 1'b0, 4'd3};
  localparam logic [21:0] VMemWb   = {8'b0000_1010, 2'b00, 2'b00, 1'b0, 4'b0010, 1'b0, 4'd4};
  localparam logic [21:0] VMemWr   = {8'b1001_0000, 2'b00, 2'b00, 1'b0, 4'b0010, 1'b0, 4'd5};
  localparam logic [21:0] VAluWb   = {8'b0000_1100, 2'b00, 2'b00, 1'b0, 4'b0010, 1'b0, 4'd7};
  localparam logic [21:0] VBrZ1    = {8'b0000_0001, 2'b00, 2'b01, 1'b1, 4'b0110, 1'b0, 4'd8};
  localparam logic [21:0] VBrZ0    = {8'b0000_0001, 2'b00, 2'b01, 1'b0, 4'b0110, 1'b0, 4'd8};
  localparam logic [21:0] VAddiEx  = {8'b0000_0001, 2'b10, 2'b00, 1'b0, 4'b0010, 1'b0, 4'd9};
  localparam logic [21:0] VAddiWb  = {8'b0000_1000, 2'b00, 2'b00, 1'b0, 4'b0010, 1'b0, 4'd10};
  localparam logic [21:0] VJump    = {8'b0000_0000, 2'b00, 2'b10, 1'b1, 4'b0010, 1'b0, 4'd11};

  function automatic logic [21:0] v_exec(input logic [3:0] alu);
    return {8'b0000_0001, 2'b00, 2'b00, 1'b0, alu, 1'b0, 4'd6};
  endfunction

  task automatic chk(input string tag, input logic [21:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are changed and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] funct_tab [6];
  logic [3:0] alu_tab   [6];

  initial begin
    funct_tab = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd9};
    alu_tab   = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111, 4'b0010};

    reset = 1'b1; op = 4'd0; funct = 4'd1; zero = 1'b0; mem_ready = 1'b1;

    // Two reset cycles, outputs all zero
    tick(); chk("reset_c1", VReset);
    tick(); chk("reset_c2", VReset);
    reset = 1'b0; #1;
    chk("post_reset_fetch", VFetchR);

    // R-type SUB: FETCH DECODE EXEC ALUWB FETCH
    op = 4'd0; funct = 4'd1;
    tick(); chk("rt_decode", VDecode);
    tick(); chk("rt_exec_sub", v_exec(4'b0110));
    tick(); chk("rt_aluwb", VAluWb);
    tick(); chk("rt_fetch", VFetchR);

    // Remaining funct mappings through EXEC
    for (int i = 0; i < 6; i++) begin
      funct = funct_tab[i];
      tick(); chk("rtx_decode", VDecode);
      tick(); chk($sformatf("rtx_exec_f%0d", funct_tab[i]), v_exec(alu_tab[i]));
      tick(); chk("rtx_aluwb", VAluWb);
      tick(); chk("rtx_fetch", VFetchR);
    end

    // LW with three wait cycles in MEMRD: 8 cycles FETCH to FETCH
    op = 4'd1;
    tick(); chk("lw_decode", VDecode);
    tick(); chk("lw_memadr", VMemAdr);
    for (int i = 0; i < 4; i++) begin
      tick();
      mem_ready = (i == 3);
      #1;
      chk($sformatf("lw_memrd_%0d", i), VMemRd);
    end
    tick(); chk("lw_memwb", VMemWb);
    tick(); chk("lw_fetch", VFetchR);

    // BEQ taken
    op = 4'd3; zero = 1'b1;
    tick(); chk("beq1_decode", VDecode);
    tick(); chk("beq1_branch", VBrZ1);
    tick(); chk("beq1_fetch", VFetchR);
    // BEQ not taken
    zero = 1'b0;
    tick(); chk("beq0_decode", VDecode);
    tick(); chk("beq0_branch", VBrZ0);
    tick(); chk("beq0_fetch", VFetchR);

    // SW with two wait cycles: memwrite held three cycles
    op = 4'd2;
    tick(); chk("sw_decode", VDecode);
    tick(); chk("sw_memadr", VMemAdr);
    for (int i = 0; i < 3; i++) begin
      tick();
      mem_ready = (i == 2);
      #1;
      chk($sformatf("sw_memwr_%0d", i), VMemWr);
    end
    tick(); chk("sw_fetch", VFetchR);

    // ADDI with one fetch wait cycle
    op = 4'd4; mem_ready = 1'b0; #1;
    chk("addi_fetch_wait", VFetchW);
    tick(); chk("addi_fetch_hold", VFetchW);
    mem_ready = 1'b1; #1;
    chk("addi_fetch_ready", VFetchR);
    tick(); chk("addi_decode", VDecode);
    tick(); chk("addi_ex", VAddiEx);
    tick(); chk("addi_wb", VAddiWb);
    tick(); chk("addi_fetch", VFetchR);

    // Jump with mem_ready low through non-memory states
    op = 4'd5;
    tick(); mem_ready = 1'b0; #1; chk("j_decode", VDecode);
    tick(); chk("j_jump", VJump);
    tick(); chk("j_fetch_wait", VFetchW);
    mem_ready = 1'b1; #1;
    chk("j_fetch_ready", VFetchR);

    // Illegal opcode
    op = 4'hA;
    tick(); chk("ill_decode", VDecIll);
    tick(); chk("ill_fetch", VFetchR);

    // SW interrupted by reset while waiting in MEMWR
    op = 4'd2;
    tick(); chk("swr_decode", VDecode);
    tick(); chk("swr_memadr", VMemAdr);
    tick(); mem_ready = 1'b0; #1; chk("swr_memwr", VMemWr);
    reset = 1'b1; #1;
    chk("swr_reset", VReset);
    tick(); reset = 1'b0; mem_ready = 1'b1; #1;
    chk("swr_fetch", VFetchR);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
